// File: rtl/time_set_ctrl_if.sv
// Purpose : user-button and counter-data bundle between the RTC time counter side and time_set_ctrl.
// Latency : pure wiring, no storage.
// Backpressure: none; buttons and counter values are level signals sampled every cycle.
// Ports   : i_btn_* raw buttons, i_cur_* counter readback, o_* load strobe/data and edit status.
interface time_set_ctrl_if;
  logic       i_btn_mode;
  logic       i_btn_up;
  logic       i_btn_down;
  logic [7:0] i_cur_msec;
  logic [7:0] i_cur_sec;
  logic [7:0] i_cur_min;
  logic [7:0] i_cur_hour;
  logic       o_modify;
  logic [7:0] o_msec;
  logic [7:0] o_sec;
  logic [7:0] o_min;
  logic [7:0] o_hour;
  logic       o_editing;
  logic [1:0] o_edit_field;
  logic       o_blink;

  // Driver side: buttons and counter readback out, controller results in.
  modport master (
    output i_btn_mode, i_btn_up, i_btn_down,
    output i_cur_msec, i_cur_sec, i_cur_min, i_cur_hour,
    input  o_modify, o_msec, o_sec, o_min, o_hour,
    input  o_editing, o_edit_field, o_blink
  );

  // Controller side.
  modport slave (
    input  i_btn_mode, i_btn_up, i_btn_down,
    input  i_cur_msec, i_cur_sec, i_cur_min, i_cur_hour,
    output o_modify, o_msec, o_sec, o_min, o_hour,
    output o_editing, o_edit_field, o_blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Purpose : debounces MODE/UP/DOWN, runs the hour/min/sec edit FSM and loads the RTC counter.
// Latency : raw button edge to press pulse DEBOUNCE_CYCLES+3 cycles; counter readback 1 cycle.
// Backpressure: none; presses are acted on the cycle they occur, o_modify is a single-cycle strobe.
// Ports   : i_clk, i_reset_n (async active-low); bus (slave) carries buttons, i_cur_* and all o_*.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int BLINK_CYCLES    = 50000000,
  parameter int TIMEOUT_CYCLES  = 1000000000
) (
  input logic            i_clk,
  input logic            i_reset_n,
  time_set_ctrl_if.slave bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BL_MAX  = BW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    EDIT_HOUR = 3'd1,
    EDIT_MIN  = 3'd2,
    EDIT_SEC  = 3'd3,
    COMMIT    = 3'd4
  } state_e;

  function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] dec_wrap(input logic [7:0] v, input logic [7:0] max);
    return (v == 8'd0) ? max : v - 8'd1;
  endfunction

  // ---------------- button debounce, bit 0 MODE, bit 1 UP, bit 2 DOWN ----------------
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d, deb_prev_q;
  logic [2:0]    press;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];

  assign raw = {bus.i_btn_down, bus.i_btn_up, bus.i_btn_mode};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_MAX) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are silent.
  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // ---------------- edit FSM ----------------
  state_e        state_q, state_d;
  logic [7:0]    edit_hour_q, edit_hour_d;
  logic [7:0]    edit_min_q, edit_min_d;
  logic [7:0]    edit_sec_q, edit_sec_d;
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic [7:0]    cur_msec_q, cur_sec_q, cur_min_q, cur_hour_q;
  logic          any_press, step_up, step_dn, in_edit;

  assign any_press = |press;
  // UP and DOWN together cancel out but still count as activity for the timeout.
  assign step_up   = press[1] & ~press[2];
  assign step_dn   = press[2] & ~press[1];
  assign in_edit   = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN) || (state_q == EDIT_SEC);

  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    edit_sec_d  = edit_sec_q;
    to_d        = to_q;
    bcnt_d      = bcnt_q;
    blink_d     = blink_q;

    case (state_q)
      RUN: begin
        to_d    = '0;
        bcnt_d  = '0;
        blink_d = 1'b1;
        if (press[0]) begin
          // Out-of-range counter values are clamped so editing starts from a legal time.
          edit_hour_d = (bus.i_cur_hour >= 8'd24) ? 8'd0 : bus.i_cur_hour;
          edit_min_d  = (bus.i_cur_min  >= 8'd60) ? 8'd0 : bus.i_cur_min;
          edit_sec_d  = (bus.i_cur_sec  >= 8'd60) ? 8'd0 : bus.i_cur_sec;
          state_d     = EDIT_HOUR;
        end
      end

      EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
        if (any_press) begin
          to_d    = '0;
          bcnt_d  = '0;
          blink_d = 1'b1;
        end else begin
          if (to_q == TO_MAX) begin
            state_d = RUN;
            to_d    = '0;
          end else begin
            to_d = to_q + TW'(1);
          end
          if (bcnt_q == BL_MAX) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end

        // MODE has priority: UP/DOWN in the same cycle are dropped.
        if (press[0]) begin
          case (state_q)
            EDIT_HOUR: state_d = EDIT_MIN;
            EDIT_MIN:  state_d = EDIT_SEC;
            default:   state_d = COMMIT;
          endcase
        end else if (step_up || step_dn) begin
          case (state_q)
            EDIT_HOUR: edit_hour_d = step_up ? inc_wrap(edit_hour_q, 8'd23) : dec_wrap(edit_hour_q, 8'd23);
            EDIT_MIN:  edit_min_d  = step_up ? inc_wrap(edit_min_q, 8'd59)  : dec_wrap(edit_min_q, 8'd59);
            default:   edit_sec_d  = step_up ? inc_wrap(edit_sec_q, 8'd59)  : dec_wrap(edit_sec_q, 8'd59);
          endcase
        end
      end

      COMMIT: begin
        state_d = RUN;
        to_d    = '0;
        bcnt_d  = '0;
        blink_d = 1'b1;
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= RUN;
      edit_hour_q <= '0;
      edit_min_q  <= '0;
      edit_sec_q  <= '0;
      to_q        <= '0;
      bcnt_q      <= '0;
      blink_q     <= 1'b1;
      cur_msec_q  <= '0;
      cur_sec_q   <= '0;
      cur_min_q   <= '0;
      cur_hour_q  <= '0;
    end else begin
      state_q     <= state_d;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      to_q        <= to_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      // Registered readback of the counter, fed back to it while not editing.
      cur_msec_q  <= bus.i_cur_msec;
      cur_sec_q   <= bus.i_cur_sec;
      cur_min_q   <= bus.i_cur_min;
      cur_hour_q  <= bus.i_cur_hour;
    end
  end

  // ---------------- outputs ----------------
  // Outside RUN the counter's data inputs carry the edit registers, so COMMIT loads them directly.
  assign bus.o_modify    = (state_q == COMMIT);
  assign bus.o_editing   = in_edit;
  assign bus.o_blink     = in_edit ? blink_q : 1'b1;
  assign bus.o_msec      = (state_q == RUN) ? cur_msec_q : 8'd0;
  assign bus.o_sec       = (state_q == RUN) ? cur_sec_q  : edit_sec_q;
  assign bus.o_min       = (state_q == RUN) ? cur_min_q  : edit_min_q;
  assign bus.o_hour      = (state_q == RUN) ? cur_hour_q : edit_hour_q;

  always_comb begin
    bus.o_edit_field = 2'd0;
    case (state_q)
      EDIT_HOUR: bus.o_edit_field = 2'd1;
      EDIT_MIN:  bus.o_edit_field = 2'd2;
      EDIT_SEC:  bus.o_edit_field = 2'd3;
      default:   bus.o_edit_field = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Purpose : directed bench for time_set_ctrl with short debounce/blink/timeout constants.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: none; buttons are held long enough to debounce and released before the next step.
module tb_time_set_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES   (8),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int mod_cnt = 0;
  int mod_base;
  logic [7:0] mh, mm, ms, mms;

  // Record every load strobe and the data presented alongside it.
  always @(negedge clk) begin
    if (bus.o_modify === 1'b1) begin
      mod_cnt++;
      mh  = bus.o_hour;
      mm  = bus.o_min;
      ms  = bus.o_sec;
      mms = bus.o_msec;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] t);
    bus.i_cur_hour = h;
    bus.i_cur_min  = m;
    bus.i_cur_sec  = s;
    bus.i_cur_msec = t;
  endtask

  // m = {down, up, mode}; 10-cycle hold then 10 cycles released.
  task automatic press(input logic [2:0] m);
    step(1);
    bus.i_btn_down = m[2];
    bus.i_btn_up   = m[1];
    bus.i_btn_mode = m[0];
    step(10);
    bus.i_btn_down = 1'b0;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_mode = 1'b0;
    step(10);
  endtask

  logic prev_b, exp_b;
  int   found, bad;

  initial begin
    bus.i_btn_mode = 1'b0;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_down = 1'b0;
    set_cur(8'd12, 8'd34, 8'd56, 8'd7);
    rst_n = 1'b0;

    // Reset state
    step(3);
    sample();
    chk("rst_modify", bus.o_modify, 0);
    chk("rst_hour", bus.o_hour, 0);
    chk("rst_msec", bus.o_msec, 0);
    chk("rst_editing", bus.o_editing, 0);
    chk("rst_field", bus.o_edit_field, 0);
    chk("rst_blink", bus.o_blink, 1);
    step(1);
    rst_n = 1'b1;
    step(2);
    sample();
    chk("run_hour_track", bus.o_hour, 12);
    chk("run_msec_track", bus.o_msec, 7);

    // 1. Debounce: short pulse ignored, 10-cycle hold gives one press 7 cycles after its edge
    step(1);
    bus.i_btn_mode = 1'b1;
    step(2);
    bus.i_btn_mode = 1'b0;
    step(12);
    sample();
    chk("short_pulse_ignored", bus.o_editing, 0);
    step(1);
    bus.i_btn_mode = 1'b1;
    step(6);
    sample();
    chk("press_not_before_7", bus.o_editing, 0);
    step(1);
    sample();
    chk("press_at_7", bus.o_editing, 1);
    chk("enter_field_hour", bus.o_edit_field, 1);
    chk("enter_hour_cap", bus.o_hour, 12);
    chk("enter_blink", bus.o_blink, 1);
    step(3);
    bus.i_btn_mode = 1'b0;
    step(15);
    sample();
    chk("single_press", bus.o_edit_field, 1);
    step(1);
    for (int i = 0; i < 20; i++) begin
      bus.i_btn_up = ~bus.i_btn_up;
      step(1);
    end
    bus.i_btn_up = 1'b0;
    step(10);
    sample();
    chk("chatter_no_press", bus.o_hour, 12);

    // 2. Edit 12:34:56 -> 15:33:56 and commit
    press(3'b010);
    press(3'b010);
    press(3'b010);
    sample();
    chk("hour_up3", bus.o_hour, 15);
    press(3'b001);
    sample();
    chk("field_min", bus.o_edit_field, 2);
    chk("edit_msec_zero", bus.o_msec, 0);
    press(3'b100);
    sample();
    chk("min_down", bus.o_min, 33);
    press(3'b001);
    sample();
    chk("field_sec", bus.o_edit_field, 3);
    mod_base = mod_cnt;
    press(3'b001);
    sample();
    chk("commit_once", mod_cnt - mod_base, 1);
    chk("commit_hour", mh, 15);
    chk("commit_min", mm, 33);
    chk("commit_sec", ms, 56);
    chk("commit_msec", mms, 0);
    chk("after_commit_run", bus.o_editing, 0);
    chk("after_commit_field", bus.o_edit_field, 0);
    chk("after_commit_track", bus.o_hour, 12);

    // 3. Wrap boundaries
    set_cur(8'd23, 8'd59, 8'd0, 8'd3);
    press(3'b001);
    sample();
    chk("cap_hour23", bus.o_hour, 23);
    press(3'b010);
    sample();
    chk("hour_wrap_up", bus.o_hour, 0);
    press(3'b100);
    sample();
    chk("hour_wrap_down", bus.o_hour, 23);
    press(3'b001);
    press(3'b010);
    sample();
    chk("min_wrap_up", bus.o_min, 0);
    press(3'b001);
    press(3'b100);
    sample();
    chk("sec_wrap_down", bus.o_sec, 59);
    mod_base = mod_cnt;
    press(3'b001);
    chk("wrap_commit_once", mod_cnt - mod_base, 1);
    chk("wrap_commit_val", {mh, mm, ms}, {8'd23, 8'd0, 8'd59});

    // 4. Simultaneous presses
    set_cur(8'd10, 8'd20, 8'd30, 8'd0);
    press(3'b001);
    press(3'b110);
    sample();
    chk("updown_hour", bus.o_hour, 10);
    chk("updown_field", bus.o_edit_field, 1);
    press(3'b011);
    sample();
    chk("modeup_field", bus.o_edit_field, 2);
    chk("modeup_hour", bus.o_hour, 10);
    chk("modeup_min", bus.o_min, 20);
    mod_base = mod_cnt;
    press(3'b001);
    press(3'b001);
    chk("simul_commit_once", mod_cnt - mod_base, 1);
    chk("simul_commit_hour", mh, 10);

    // 5. Clamp at capture, then timeout abandons edit
    set_cur(8'd30, 8'd61, 8'd45, 8'd9);
    mod_base = mod_cnt;
    press(3'b001);
    sample();
    chk("clamp_hour", bus.o_hour, 0);
    chk("clamp_min", bus.o_min, 0);
    chk("clamp_sec_kept", bus.o_sec, 45);
    step(150);
    sample();
    chk("timeout_not_yet", bus.o_editing, 1);
    step(60);
    sample();
    chk("timeout_run", bus.o_editing, 0);
    chk("timeout_no_modify", mod_cnt - mod_base, 0);
    chk("timeout_track_hour", bus.o_hour, 30);
    chk("timeout_track_msec", bus.o_msec, 9);
    step(1);
    bus.i_cur_hour = 8'd5;
    sample();
    chk("track_latency_old", bus.o_hour, 30);
    sample();
    chk("track_latency_new", bus.o_hour, 5);

    // 6. Reset mid-edit, then blink period
    set_cur(8'd8, 8'd9, 8'd10, 8'd1);
    press(3'b001);
    press(3'b001);
    sample();
    chk("pre_reset_field", bus.o_edit_field, 2);
    mod_base = mod_cnt;
    step(1);
    rst_n = 1'b0;
    #2;
    chk("midrst_editing", bus.o_editing, 0);
    chk("midrst_modify", bus.o_modify, 0);
    chk("midrst_blink", bus.o_blink, 1);
    chk("midrst_field", bus.o_edit_field, 0);
    chk("midrst_vals", {bus.o_hour, bus.o_min, bus.o_sec, bus.o_msec}, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    sample();
    chk("postrst_track", {bus.o_hour, bus.o_min, bus.o_sec}, {8'd8, 8'd9, 8'd10});
    chk("postrst_no_modify", mod_cnt - mod_base, 0);
    chk("postrst_run", bus.o_editing, 0);

    press(3'b001);
    sample();
    prev_b = bus.o_blink;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (bus.o_blink !== prev_b) found = 1;
    end
    chk("blink_found", found, 1);
    prev_b = bus.o_blink;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (bus.o_blink !== prev_b) bad++;
    end
    chk("blink_hold7", bad, 0);
    exp_b = ~prev_b;
    @(negedge clk);
    chk("blink_toggle8", bus.o_blink, exp_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
